// File: rtl/serial_add_arbiter_if.sv
// Request/grant/result bundle between two add clients and serial_add_arbiter.
// Clients drive through the master modport, the arbiter uses the slave modport.
interface serial_add_arbiter_if #(
    parameter int WIDTH = 8
) ();
    logic             req0;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             cin0;
    logic             req1;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             cin1;
    logic             gnt0;
    logic             gnt1;
    logic             owner;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output req0, a0, b0, cin0,
        output req1, a1, b1, cin1,
        input  gnt0, gnt1, owner, busy, done, sum, cout
    );

    modport slave (
        input  req0, a0, b0, cin0,
        input  req1, a1, b1, cin1,
        output gnt0, gnt1, owner, busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_arbiter.sv
// Bit-serial adder shared by two requesters: round-robin capture, WIDTH cycles
// of LSB-first addition through one full-adder cell, then a one-cycle done.

module serial_add_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    serial_add_arbiter_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             last_bit;
    logic             last_grant;
    logic             owner_q;
    logic             take;
    logic             winner;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign take     = (state == IDLE) && (bus.req0 || bus.req1);
    // On a tie the requester that did not win last time goes first.
    assign winner   = (bus.req0 && bus.req1) ? ~last_grant : bus.req1;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    serial_add_fa u_fa (
        .a  (op_a[0]),
        .b  (op_b[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Control and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            last_grant <= 1'b1;
            owner_q    <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
        end else begin
            if (take) begin
                cnt        <= '0;
                owner_q    <= winner;
                last_grant <= winner;
            end else if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
                if (last_bit) begin
                    sum_q  <= {fa_s, op_a[WIDTH-1:1]};
                    cout_q <= fa_co;
                end
            end
        end
    end

    // Operand shifters and carry flop; sum bits refill op_a from the MSB side
    // as its operand bits are consumed, so op_a doubles as the result shifter.
    always_ff @(posedge clk) begin
        if (take) begin
            op_a  <= winner ? bus.a1 : bus.a0;
            op_b  <= winner ? bus.b1 : bus.b0;
            carry <= winner ? bus.cin1 : bus.cin0;
        end else if (state == RUN) begin
            op_a  <= {fa_s, op_a[WIDTH-1:1]};
            op_b  <= op_b >> 1;
            carry <= fa_co;
        end
    end

    // Outputs: grant is the first RUN cycle, the one right after capture
    always_comb begin
        bus.gnt0  = (state == RUN) && (cnt == '0) && !owner_q;
        bus.gnt1  = (state == RUN) && (cnt == '0) && owner_q;
        bus.owner = owner_q;
        bus.busy  = (state != IDLE);
        bus.done  = (state == DONE);
        bus.sum   = sum_q;
        bus.cout  = cout_q;
    end
endmodule

// File: tb/tb_serial_add_arbiter.sv
// Bench for serial_add_arbiter: vector table, arbitration, ignore-in-RUN,
// mid-operation reset and random operands, results checked via a scoreboard.
module tb_serial_add_arbiter;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    serial_add_arbiter_if #(.WIDTH(WIDTH)) bus ();

    serial_add_arbiter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             port;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } vec_t;

    typedef struct {
        logic             owner;
        logic [WIDTH-1:0] sum;
        logic             cout;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   total = 0;
    int   bad   = 0;
    logic prev_busy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Grant sanity and result scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.gnt0 || bus.gnt1) begin
                check("gnt_single", 32'(bus.gnt0 & bus.gnt1), 0);
                check("gnt_after_idle", 32'(prev_busy), 0);
                check("gnt_busy", 32'(bus.busy), 1);
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    check("done_unexpected", 32'(bus.done), 0);
                end else begin
                    e = sb.pop_front();
                    check("sum", 32'(bus.sum), 32'(e.sum));
                    check("cout", 32'(bus.cout), 32'(e.cout));
                    check("owner", 32'(bus.owner), 32'(e.owner));
                end
            end
        end
        prev_busy <= bus.busy;
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt0"}, 32'(bus.gnt0), 0);
        check({tag, "_gnt1"}, 32'(bus.gnt1), 0);
        check({tag, "_owner"}, 32'(bus.owner), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_done"}, 32'(bus.done), 0);
        check({tag, "_sum"}, 32'(bus.sum), 0);
        check({tag, "_cout"}, 32'(bus.cout), 0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60; i++) begin
            if (sb.size() == 0 && !bus.busy) break;
            @(negedge clk);
        end
        check("drain", 32'(sb.size()) | 32'(bus.busy), 0);
    endtask

    task automatic run_op(input logic p, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic [WIDTH-1:0] es, input logic ec);
        bit got = 0;
        int lat = 0;
        if (p) begin
            bus.req1 = 1'b1; bus.a1 = a; bus.b1 = b; bus.cin1 = cin;
        end else begin
            bus.req0 = 1'b1; bus.a0 = a; bus.b0 = b; bus.cin0 = cin;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (p ? bus.gnt1 : bus.gnt0) begin
                got = 1;
                break;
            end
        end
        check("gnt_seen", 32'(got), 1);
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        if (!got) return;
        sb.push_back('{owner: p, sum: es, cout: ec});
        for (int i = 1; i <= WIDTH + 5; i++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        check("done_latency", 32'(lat), WIDTH);
        @(negedge clk);
        check("busy_fall", 32'(bus.busy), 0);
    endtask

    initial begin : main
        int               n;
        int               dn;
        int               g1;
        int               ndone;
        logic             g;
        logic             p;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        logic [WIDTH:0]   model;

        vecs[0] = '{1'b0, 8'h03, 8'h05, 1'b0, 8'h08, 1'b0};
        vecs[1] = '{1'b1, 8'h7F, 8'h80, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[3] = '{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{1'b1, 8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0};
        vecs[6] = '{1'b1, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[7] = '{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[8] = '{1'b0, 8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
        vecs[9] = '{1'b1, 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1};

        bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.cin0 = 1'b0;
        bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.cin1 = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Both requesters held: grants must alternate starting with 0
        bus.a0 = 8'h11; bus.b0 = 8'h22; bus.cin0 = 1'b0;
        bus.a1 = 8'hF0; bus.b1 = 8'h20; bus.cin1 = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        n = 0;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) begin
                g = bus.gnt1;
                check("arb_order", 32'(g), 32'(n % 2));
                if (g) sb.push_back('{owner: 1'b1, sum: 8'h11, cout: 1'b1});
                else   sb.push_back('{owner: 1'b0, sum: 8'h33, cout: 1'b0});
                n++;
            end
        end
        check("arb_count", 32'(n), 4);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        wait_drain();

        for (int i = 0; i < 10; i++)
            run_op(vecs[i].port, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout);

        // req1 arrives during RUN; requester 0 scribbles its operands after grant
        bus.a0 = 8'h10; bus.b0 = 8'h20; bus.cin0 = 1'b0; bus.req0 = 1'b1;
        g = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.gnt0) begin g = 1'b1; break; end
        end
        check("ignore_gnt0", 32'(g), 1);
        sb.push_back('{owner: 1'b0, sum: 8'h30, cout: 1'b0});
        bus.req0 = 1'b0;
        bus.a0 = 8'hFF; bus.b0 = 8'hFF; bus.cin0 = 1'b1;
        bus.a1 = 8'h01; bus.b1 = 8'h02; bus.cin1 = 1'b0; bus.req1 = 1'b1;
        dn = 0; g1 = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.done && dn == 0) dn = i;
            if (bus.gnt1) begin g1 = i; break; end
        end
        check("ignore_done_at", 32'(dn), WIDTH);
        check("ignore_gnt1_at", 32'(g1), WIDTH + 2);
        if (g1 != 0) sb.push_back('{owner: 1'b1, sum: 8'h03, cout: 1'b0});
        bus.req1 = 1'b0;
        wait_drain();

        // Reset while requester 1's op is on bit 4
        bus.a1 = 8'h0F; bus.b1 = 8'h01; bus.cin1 = 1'b0; bus.req1 = 1'b1;
        g = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.gnt1) begin g = 1'b1; break; end
        end
        check("rst_gnt1", 32'(g), 1);
        bus.req1 = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        rst = 1'b0;
        ndone = 0;
        repeat (WIDTH + 4) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        check("midrst_no_done", 32'(ndone), 0);

        bus.a0 = 8'h01; bus.b0 = 8'h02; bus.cin0 = 1'b0;
        bus.a1 = 8'h04; bus.b1 = 8'h08; bus.cin1 = 1'b1;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        g = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.gnt0 || bus.gnt1) begin g = 1'b1; break; end
        end
        check("rst_tie_seen", 32'(g), 1);
        check("rst_tie_req0", 32'(bus.gnt0), 1);
        if (bus.gnt0) sb.push_back('{owner: 1'b0, sum: 8'h03, cout: 1'b0});
        bus.req0 = 1'b0;
        g = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.gnt1) begin g = 1'b1; break; end
        end
        check("rst_then_gnt1", 32'(g), 1);
        if (g) sb.push_back('{owner: 1'b1, sum: 8'h0D, cout: 1'b0});
        bus.req1 = 1'b0;
        wait_drain();

        for (int i = 0; i < 500; i++) begin
            p  = 1'($urandom_range(0, 1));
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            rc = 1'($urandom_range(0, 1));
            model = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
            run_op(p, ra, rb, rc, model[WIDTH-1:0], model[WIDTH]);
        end
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
